// File: rtl/mem_responder.sv
// Byte-wide memory responder: address strobe, then a two-cycle read or a single-cycle write.
// Optional write protection of the low 256 bytes with MEM_RESPONDER_WRITE_PROTECT_EN.
module mem_responder #(
  parameter int DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        address_read,
  input  logic        data_in,
  input  logic        data_out,
  input  logic        mem_enable,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        bus_error
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARMED = 2'd1;
  localparam logic [1:0] READ1 = 2'd2;
  localparam logic [1:0] READ2 = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [15:0]   addr_q;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] idx;
  logic          rd_en, wr_en, in_range, prot;
  logic          err_nxt, latch, mem_we, rd_load;

  assign rd_en    = mem_enable & data_in;
  assign wr_en    = mem_enable & data_out;
  assign in_range = addr_q < 16'(DEPTH);
  assign idx      = addr_q[AW-1:0];

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
  assign prot = addr_q < 16'h0100;
`else
  assign prot = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    latch     = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    if (state == READ1) begin
      // A read must complete with exactly one more read strobe.
      if (address_read || !rd_en || wr_en) begin
        err_nxt   = 1'b1;
        state_nxt = IDLE;
      end else begin
        state_nxt = READ2;
      end
    end else if (address_read) begin
      latch     = 1'b1;
      state_nxt = ARMED;
    end else if (rd_en && wr_en) begin
      err_nxt   = 1'b1;
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (rd_en || wr_en) err_nxt = 1'b1;
        end
        ARMED: begin
          if (rd_en) begin
            state_nxt = READ1;
            rd_load   = 1'b1;
            if (!in_range) err_nxt = 1'b1;
          end else if (wr_en) begin
            state_nxt = IDLE;
            if (in_range && !prot) mem_we  = 1'b1;
            else                   err_nxt = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= 16'h0000;
      rdata     <= 8'h00;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      bus_error <= err_nxt;
      if (latch)   addr_q <= addr;
      if (rd_load) rdata  <= in_range ? mem[idx] : 8'h00;
    end
  end

  // Array is never cleared; reset only blocks a coincident write.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx] <= wdata;
  end

  assign rdata_valid = (state == READ2);

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: table-driven write/read vectors with a read-data
// scoreboard, plus hand sequences for aborts, re-latch, range, reset and protection.
module tb_mem_responder;

  localparam int DEPTH = 1024;
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, address_read, data_in, data_out, mem_enable;
  logic [15:0] addr;
  logic [7:0]  wdata, rdata;
  logic        rdata_valid, bus_error;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb [$];

  mem_responder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .address_read(address_read), .data_in(data_in),
    .data_out(data_out), .mem_enable(mem_enable), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    bit          gap;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    address_read = 0; data_in = 0; data_out = 0; mem_enable = 0;
  endtask

  // Scoreboard: every cycle with rdata_valid must match the oldest queued read.
  always @(negedge clk) begin
    if (reset === 1'b0 && rdata_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_valid: rdata %0h with nothing expected at %0t", rdata, $time);
      end else if (rdata !== sb[0]) begin
        errors++;
        $display("FAIL sb_rdata: got %0h expected %0h at %0t", rdata, sb[0], $time);
      end
      if (sb.size() != 0) void'(sb.pop_front());
    end
  end

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit gap,
                          input logic exp_err);
    idle_in(); address_read = 1; addr = a; tick();
    address_read = 0;
    if (gap) tick();
    data_out = 1; mem_enable = 1; wdata = d; tick();
    idle_in();
    chk("wr_err", 16'(bus_error), 16'(exp_err));
    tick();
    chk("wr_err_clr", 16'(bus_error), 16'd0);
  endtask

  task automatic do_read(input logic [15:0] a, input logic [7:0] exp, input logic exp_err);
    idle_in(); address_read = 1; addr = a; tick();
    address_read = 0; data_in = 1; mem_enable = 1; tick();
    chk("rd1_valid", 16'(rdata_valid), 16'd0);
    chk("rd1_err", 16'(bus_error), 16'(exp_err));
    chk("rd1_rdata", 16'(rdata), 16'(exp));
    sb.push_back(exp);
    tick();
    chk("rd2_valid", 16'(rdata_valid), 16'd1);
    chk("rd2_err", 16'(bus_error), 16'd0);
    idle_in(); tick();
    chk("rd_done_valid", 16'(rdata_valid), 16'd0);
    chk("rd_hold", 16'(rdata), 16'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    logic [7:0] old;
    tbl[0] = '{16'h0123, 8'hA5, 1'b1};
    tbl[1] = '{16'h0000, 8'h3C, 1'b0};
    tbl[2] = '{16'h03FF, 8'hC3, 1'b0};
    tbl[3] = '{16'h0200, 8'h5A, 1'b1};
    tbl[4] = '{16'h0400, 8'h5A, 1'b0};
    tbl[5] = '{16'h0100, 8'h81, 1'b0};

    idle_in(); addr = 0; wdata = 0; reset = 1;
    tick();
    data_in = 1; mem_enable = 1; tick();
    chk("rst_rdata", 16'(rdata), 16'd0);
    chk("rst_valid", 16'(rdata_valid), 16'd0);
    chk("rst_err", 16'(bus_error), 16'd0);
    idle_in(); reset = 0; tick();
    chk("rst_idle_err", 16'(bus_error), 16'd0);

    for (int i = 0; i < 6; i++)
      do_write(tbl[i].a, tbl[i].d, tbl[i].gap,
               (tbl[i].a >= 16'(DEPTH)) || (PROT && tbl[i].a < 16'h0100));
    for (int i = 0; i < 6; i++) begin
      if (!(PROT && tbl[i].a < 16'h0100))
        do_read(tbl[i].a, (tbl[i].a >= 16'(DEPTH)) ? 8'h00 : tbl[i].d,
                tbl[i].a >= 16'(DEPTH));
    end

    // Re-latch in ARMED: the second address wins.
    do_write(16'h0110, 8'h11, 0, 0);
    do_write(16'h0120, 8'h22, 0, 0);
    idle_in(); address_read = 1; addr = 16'h0110; tick();
    addr = 16'h0120; tick();
    address_read = 0; data_in = 1; mem_enable = 1; tick();
    chk("relatch_rdata", 16'(rdata), 16'h22);
    sb.push_back(8'h22);
    tick(); idle_in(); tick();
    do_read(16'h0110, 8'h11, 0);

    // Aborted read: one strobe then nothing.
    idle_in(); address_read = 1; addr = 16'h0123; tick();
    address_read = 0; data_in = 1; mem_enable = 1; tick();
    idle_in(); tick();
    chk("abort_err", 16'(bus_error), 16'd1);
    chk("abort_valid", 16'(rdata_valid), 16'd0);
    tick();
    chk("abort_err_pulse", 16'(bus_error), 16'd0);
    do_read(16'h0123, 8'hA5, 0);

    // Address strobe during READ1.
    idle_in(); address_read = 1; addr = 16'h0123; tick();
    address_read = 0; data_in = 1; mem_enable = 1; tick();
    address_read = 1; addr = 16'h0200; tick();
    chk("r1_addr_err", 16'(bus_error), 16'd1);
    chk("r1_addr_valid", 16'(rdata_valid), 16'd0);
    idle_in(); tick();
    chk("r1_addr_clr", 16'(bus_error), 16'd0);

    // Back-to-back errors from strobes in IDLE.
    data_in = 1; mem_enable = 1; tick();
    chk("b2b_err0", 16'(bus_error), 16'd1);
    tick();
    chk("b2b_err1", 16'(bus_error), 16'd1);
    idle_in(); tick();
    chk("b2b_clr", 16'(bus_error), 16'd0);

    // Read and write strobes together: error, no write.
    address_read = 1; addr = 16'h0100; tick();
    address_read = 0; data_in = 1; data_out = 1; mem_enable = 1; wdata = 8'hEE; tick();
    chk("both_err", 16'(bus_error), 16'd1);
    idle_in(); tick();
    do_read(16'h0100, 8'h81, 0);

    // Strobes without mem_enable are ignored; ARMED is held.
    address_read = 1; addr = 16'h0200; tick();
    address_read = 0; data_in = 1; tick();
    data_in = 0; data_out = 1; wdata = 8'h99; tick();
    chk("noen_err", 16'(bus_error), 16'd0);
    mem_enable = 1; wdata = 8'h66; tick();
    chk("noen_wr_err", 16'(bus_error), 16'd0);
    idle_in(); tick();
    do_read(16'h0200, 8'h66, 0);

    // Reset during READ1.
    address_read = 1; addr = 16'h0123; tick();
    address_read = 0; data_in = 1; mem_enable = 1; tick();
    chk("rstr1_pre", 16'(rdata), 16'hA5);
    reset = 1; tick();
    chk("rstr1_valid", 16'(rdata_valid), 16'd0);
    chk("rstr1_rdata", 16'(rdata), 16'd0);
    reset = 0; idle_in(); tick();
    chk("rstr1_after", 16'(rdata_valid), 16'd0);

    // Write coincident with reset must not land.
    address_read = 1; addr = 16'h0123; tick();
    address_read = 0; data_out = 1; mem_enable = 1; wdata = 8'h11; reset = 1; tick();
    reset = 0; idle_in(); tick();
    do_read(16'h0123, 8'hA5, 0);

    if (PROT) begin
      address_read = 1; addr = 16'h00FF; tick();
      address_read = 0; data_in = 1; mem_enable = 1; tick();
      old = rdata;
      sb.push_back(old);
      tick(); idle_in(); tick();
      do_write(16'h00FF, 8'h77, 0, 1);
      do_read(16'h00FF, old, 0);
      do_write(16'h0100, 8'h99, 0, 0);
      do_read(16'h0100, 8'h99, 0);
    end else begin
      do_write(16'h00FF, 8'h77, 0, 0);
      do_read(16'h00FF, 8'h77, 0);
    end

    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: address_read  input  1  initiator address strobe; addr valid this cycle.
REQ-004 SHALL have port: data_in  input  1  initiator read strobe (data flows memory -> initiator).
REQ-005 SHALL have port: data_out  input  1  initiator write strobe (data flows initiator -> memory).
REQ-006 SHALL have port: mem_enable  input  1  qualifies data_in/data_out.
REQ-007 SHALL have port: addr  input  16  byte address, sampled only with address_read.
REQ-008 SHALL have port: wdata  input  8  write data, sampled only on a write cycle.
REQ-009 SHALL have port: rdata  output  8  registered read data.
REQ-010 SHALL have port: rdata_valid  output  1  high exactly in the second read cycle.
REQ-011 SHALL have port: bus_error  output  1  one-cycle pulse on protocol or range error.
REQ-012 SHALL have parameter: DEPTH, default 1024, byte count of internal array (power of two, 256..4096).

Function
REQ-013 SHALL implement states IDLE, ARMED, READ1, READ2.
REQ-014 Any state except READ1, address_read=1: addr_q <= addr, next state ARMED (re-latch allowed in ARMED).
REQ-015 ARMED, no strobe: hold ARMED indefinitely (a gap cycle between address and data is legal).
REQ-016 ARMED, data_in&mem_enable: next READ1; at that edge rdata <= mem[addr_q] (0x00 if out of range).
REQ-017 READ1, data_in&mem_enable: next READ2; rdata unchanged; rdata_valid=1 during READ2.
REQ-018 READ2: next IDLE unless address_read=1 (then REQ-014); rdata holds last value until next read.
REQ-019 ARMED, data_out&mem_enable: mem[addr_q] <= wdata at that edge; next IDLE; single-cycle write.
REQ-020 Read latency: rdata valid in the cycle after the first read-strobe cycle; rdata_valid combinationally decoded from state.
REQ-021 Range: addr_q >= DEPTH is out of range; reads return 0x00, writes dropped, bus_error pulses next cycle; no aliasing.
REQ-022 Errors (bus_error=1 next cycle, next state IDLE, no memory write): data_in&data_out both with mem_enable; strobe with mem_enable in IDLE; READ1 without data_in&mem_enable; address_read in READ1.
REQ-023 data_in/data_out without mem_enable SHALL be ignored (no error, no transition).
REQ-024 bus_error SHALL be a registered single-cycle pulse; back-to-back errors produce back-to-back pulses.

Reset
REQ-025 reset=1 at an edge: state IDLE, addr_q 0x0000, rdata 0x00, bus_error 0; rdata_valid 0 the cycle after.
REQ-026 reset SHALL take priority over every strobe; a write coincident with reset SHALL NOT modify memory.
REQ-027 Memory array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_RESPONDER_WRITE_PROTECT_EN defined: writes with addr_q < 0x0100 dropped, bus_error pulses, state IDLE; reads unaffected.
REQ-029 Macro undefined: no protected region; all in-range writes succeed.

Verification
REQ-030 Write/read: addr 0x0123 strobe, gap cycle, write 0xA5; addr 0x0123, two read cycles -> rdata_valid high cycle 2, rdata 0xA5.
REQ-031 Re-latch: addr 0x0010 then addr 0x0020 in ARMED, read -> data of 0x0020; 0x0010 untouched.
REQ-032 Aborted read: ARMED, one read cycle, then idle -> bus_error one cycle, rdata_valid never high, state IDLE.
REQ-033 Out of range (DEPTH=1024): write 0x5A to 0x0400 -> bus_error; read 0x0400 -> rdata 0x00; read 0x0000 unchanged.
REQ-034 Reset mid-op: reset in READ1 -> rdata_valid 0 next cycle, rdata 0x00; reset with write strobe -> memory unchanged.
REQ-035 Protect: with MEM_RESPONDER_WRITE_PROTECT_EN, write 0x77 to 0x00FF -> bus_error, readback old value; write to 0x0100 succeeds.
